// File: rtl/segasys1_sndcmd.sv
// Sound-command FIFO between the main CPU and the sound Z80: queues command bytes, presents the
// head byte on the command port and raises an NMI with a guaranteed low gap between requests.
module segasys1_sndcmd #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned NMI_GAP    = 32
) (
  input  logic                  CLK48M,
  input  logic                  RESET,
  input  logic                  SNDRQ,
  input  logic [7:0]            SNDNO,
  input  logic                  SCPU_RD,
  output logic [7:0]            SCPU_DO,
  output logic                  SNDNMI,
  output logic                  FULL,
  output logic                  OVF,
  output logic [DEPTH_LOG2:0]   COUNT
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned GapW  = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [GapW-1:0] GapLoad = GapW'(NMI_GAP - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StWaitPop, StGap} state_e;

  logic            r_rq_d, r_rd_d;
  logic [7:0]      r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic [7:0]      r_do;
  logic            r_full, r_ovf, r_nmi;
  state_e          r_state;
  logic [GapW-1:0] r_gap;

  logic            w_push_ev, w_ack_ev, w_pop_ev;
  logic            w_do_push, w_do_pop;
  logic [PtrW-1:0] w_wptr_n, w_rptr_n;
  logic [CntW-1:0] w_count_n;
  logic [7:0]      w_head_n;
  state_e          w_state_n;
  logic [GapW-1:0] w_gap_n;

  assign w_push_ev = SNDRQ & ~r_rq_d;
  assign w_ack_ev  = SCPU_RD & ~r_rd_d;
  assign w_pop_ev  = ~SCPU_RD & r_rd_d;

  // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
  assign w_do_pop  = w_pop_ev & (r_count != '0);
  assign w_do_push = w_push_ev & ((r_count != CntFull) | w_do_pop);

  always_comb begin
    w_wptr_n  = w_do_push ? r_wptr + PtrW'(1) : r_wptr;
    w_rptr_n  = w_do_pop  ? r_rptr + PtrW'(1) : r_rptr;
    w_count_n = r_count + CntW'(w_do_push) - CntW'(w_do_pop);
    // Bypass the incoming byte when it lands exactly at the new head slot.
    w_head_n  = (w_do_push && (r_wptr == w_rptr_n)) ? SNDNO : r_mem[w_rptr_n];
  end

  always_ff @(posedge CLK48M) begin
    if (w_do_push) r_mem[r_wptr] <= SNDNO;
  end

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      r_rq_d  <= SNDRQ;
      r_rd_d  <= SCPU_RD;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_do    <= 8'h00;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_rq_d  <= SNDRQ;
      r_rd_d  <= SCPU_RD;
      r_wptr  <= w_wptr_n;
      r_rptr  <= w_rptr_n;
      r_count <= w_count_n;
      r_full  <= (w_count_n == CntFull);
      if (w_count_n != '0) r_do <= w_head_n;
      if (w_push_ev && !w_do_push) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_gap_n   = r_gap;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) w_state_n = StAssert;
      end
      StAssert: begin
        // A missed read edge still counts: the pop alone retires the request.
        if (w_pop_ev) begin
          w_state_n = StGap;
          w_gap_n   = GapLoad;
        end else if (w_ack_ev) begin
          w_state_n = StWaitPop;
        end
      end
      StWaitPop: begin
        if (w_pop_ev) begin
          w_state_n = StGap;
          w_gap_n   = GapLoad;
        end
      end
      StGap: begin
        if (r_gap == '0) w_state_n = StIdle;
        else             w_gap_n   = r_gap - GapW'(1);
      end
      default: w_state_n = StIdle;
    endcase
  end

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      r_state <= StIdle;
      r_gap   <= '0;
      r_nmi   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gap   <= w_gap_n;
      r_nmi   <= (w_state_n == StAssert);
    end
  end

  assign SCPU_DO = r_do;
  assign SNDNMI  = r_nmi;
  assign FULL    = r_full;
  assign OVF     = r_ovf;
  assign COUNT   = r_count;

endmodule

// File: tb/tb_segasys1_sndcmd.sv
// Directed bench for segasys1_sndcmd: hand-computed expectations for push, ack/pop, NMI gap,
// overflow, simultaneous events, reset and pointer wrap.
module tb_segasys1_sndcmd;

  localparam int unsigned Gap = 32;

  logic       CLK48M;
  logic       RESET;
  logic       SNDRQ;
  logic [7:0] SNDNO;
  logic       SCPU_RD;
  logic [7:0] SCPU_DO;
  logic       SNDNMI;
  logic       FULL;
  logic       OVF;
  logic [2:0] COUNT;

  int n_vec;
  int n_miscmp;
  int n;

  segasys1_sndcmd #(
    .DEPTH_LOG2 (2),
    .NMI_GAP    (Gap)
  ) u_dut (
    .CLK48M  (CLK48M),
    .RESET   (RESET),
    .SNDRQ   (SNDRQ),
    .SNDNO   (SNDNO),
    .SCPU_RD (SCPU_RD),
    .SCPU_DO (SCPU_DO),
    .SNDNMI  (SNDNMI),
    .FULL    (FULL),
    .OVF     (OVF),
    .COUNT   (COUNT)
  );

  initial CLK48M = 1'b0;
  always #5 CLK48M = ~CLK48M;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    SNDNO = b;
    SNDRQ = 1'b1;
    step();
    SNDRQ = 1'b0;
    step();
  endtask

  task automatic read_cycle(input int hi);
    SCPU_RD = 1'b1;
    repeat (hi) step();
    SCPU_RD = 1'b0;
    step();
  endtask

  // Edges after the current one until SNDNMI is seen high, capped at bound.
  task automatic wait_nmi(input int bound, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (SNDNMI !== 1'b1 && cnt < bound);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    step();
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    RESET    = 1'b1;
    SNDRQ    = 1'b0;
    SNDNO    = 8'h00;
    SCPU_RD  = 1'b0;
    step();
    step();
    RESET = 1'b0;
    step();
    check_eq("rst_count", COUNT, 0);
    check_eq("rst_do",    SCPU_DO, 8'h00);
    check_eq("rst_nmi",   SNDNMI, 0);
    check_eq("rst_full",  FULL, 0);
    check_eq("rst_ovf",   OVF, 0);

    // Single command, 16-cycle strobe
    SNDNO = 8'h5A;
    SNDRQ = 1'b1;
    step();
    check_eq("t1_count", COUNT, 1);
    check_eq("t1_do",    SCPU_DO, 8'h5A);
    check_eq("t1_nmi_k", SNDNMI, 0);
    step();
    check_eq("t1_nmi_k1", SNDNMI, 1);
    repeat (14) step();
    SNDRQ = 1'b0;
    step();
    check_eq("t1_one_push", COUNT, 1);
    SCPU_RD = 1'b1;
    step();
    check_eq("t1_ack_nmi", SNDNMI, 0);
    check_eq("t1_ack_cnt", COUNT, 1);
    repeat (7) step();
    SCPU_RD = 1'b0;
    step();
    check_eq("t1_pop_cnt", COUNT, 0);
    check_eq("t1_pop_do",  SCPU_DO, 8'h5A);
    wait_nmi(60, n);
    check_eq("t1_nmi_stay_low", SNDNMI, 0);

    // Queue of three with NMI re-assert timing
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    check_eq("t2_count", COUNT, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2_do_%0d", i), SCPU_DO, 32'(8'h01 + i));
      read_cycle(4);
      check_eq($sformatf("t2_cnt_%0d", i), COUNT, 32'(2 - i));
      wait_nmi(60, n);
      if (i < 2) check_eq($sformatf("t2_gap_%0d", i), n, Gap + 1);
      else       check_eq("t2_no_reassert", SNDNMI, 0);
    end
    check_eq("t2_do_hold", SCPU_DO, 8'h03);

    // Overflow
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i));
    check_eq("t3_full", FULL, 1);
    check_eq("t3_ovf_pre", OVF, 0);
    push_byte(8'h14);
    check_eq("t3_ovf", OVF, 1);
    check_eq("t3_count", COUNT, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_drain_%0d", i), SCPU_DO, 32'(8'h10 + i));
      read_cycle(4);
    end
    check_eq("t3_empty", COUNT, 0);
    check_eq("t3_full_clr", FULL, 0);
    check_eq("t3_ovf_sticky", OVF, 1);
    do_reset();
    check_eq("t3_ovf_reset", OVF, 0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    check_eq("t4_full", FULL, 1);
    SCPU_RD = 1'b1;
    step();
    SCPU_RD = 1'b0;
    SNDNO   = 8'hEE;
    SNDRQ   = 1'b1;
    step();
    check_eq("t4_count", COUNT, 4);
    check_eq("t4_ovf",   OVF, 0);
    check_eq("t4_do",    SCPU_DO, 8'hA1);
    SNDRQ = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t4_drain_%0d", i), SCPU_DO, (i == 3) ? 32'hEE : 32'(8'hA1 + i));
      read_cycle(2);
    end
    check_eq("t4_empty", COUNT, 0);

    // Simultaneous push and pop on an empty FIFO
    SCPU_RD = 1'b1;
    step();
    SCPU_RD = 1'b0;
    SNDNO   = 8'hEF;
    SNDRQ   = 1'b1;
    step();
    check_eq("t4e_count", COUNT, 1);
    check_eq("t4e_do",    SCPU_DO, 8'hEF);
    check_eq("t4e_ovf",   OVF, 0);
    SNDRQ = 1'b0;
    step();
    read_cycle(2);
    check_eq("t4e_empty", COUNT, 0);

    // Reset mid-operation with SNDRQ held across release
    push_byte(8'h31);
    SNDNO = 8'h32;
    SNDRQ = 1'b1;
    step();
    wait_nmi(80, n);
    check_eq("t5_pre_nmi", SNDNMI, 1);
    check_eq("t5_pre_cnt", COUNT, 2);
    RESET = 1'b1;
    step();
    step();
    check_eq("t5_in_cnt", COUNT, 0);
    check_eq("t5_in_nmi", SNDNMI, 0);
    RESET = 1'b0;
    step();
    step();
    check_eq("t5_cnt",  COUNT, 0);
    check_eq("t5_do",   SCPU_DO, 8'h00);
    check_eq("t5_nmi",  SNDNMI, 0);
    check_eq("t5_full", FULL, 0);
    check_eq("t5_ovf",  OVF, 0);
    SNDRQ = 1'b0;
    repeat (4) step();
    check_eq("t5_no_push", COUNT, 0);
    check_eq("t5_nmi_low", SNDNMI, 0);

    // Pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      SNDNO = 8'(8'h80 + i);
      SNDRQ = 1'b1;
      step();
      check_eq($sformatf("t6_do_%0d", i), SCPU_DO, 32'(8'h80 + i));
      check_eq($sformatf("t6_cnt_%0d", i), COUNT, 1);
      SNDRQ = 1'b0;
      step();
      read_cycle(2);
      check_eq($sformatf("t6_empty_%0d", i), COUNT, 0);
    end
    check_eq("t6_ovf", OVF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/segasys1_sndcmd.md
# segasys1_sndcmd

Sound-command buffer between the main CPU and the sound CPU. It takes the main-CPU command strobe `SNDRQ` and command byte `SNDNO` and queues the bytes in a small FIFO. It presents the oldest byte to the sound CPU's command port and generates an edge-friendly NMI for the sound Z80 until every queued command has been read. It lives in the 48 MHz domain next to the main CPU block; the sound CPU reads it through its own data selector.

## Interface

Parameters:
- `DEPTH_LOG2`, default 2: FIFO holds 2^DEPTH_LOG2 bytes (default 4).
- `NMI_GAP`, default 32: number of `CLK48M` cycles `SNDNMI` stays low after a pop before it may re-assert.

Ports:
- `CLK48M`  in  1  sole clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset, sampled on `CLK48M`.
- `SNDRQ`  in  1  main-CPU write strobe, level; may stay high for many cycles. One rising edge is one push.
- `SNDNO`  in  8  command byte; sampled on the cycle the `SNDRQ` rising edge is detected.
- `SCPU_RD`  in  1  sound-CPU read strobe of the command port, level. A rising edge acknowledges the NMI; a falling edge pops.
- `SCPU_DO`  out  8  registered head-of-FIFO byte. When the FIFO is empty it holds the last value.
- `SNDNMI`  out  1  registered NMI request to the sound CPU.
- `FULL`  out  1  registered; 1 when count == 2^DEPTH_LOG2.
- `OVF`  out  1  sticky overflow flag; cleared only by `RESET`.
- `COUNT`  out  DEPTH_LOG2+1  current number of queued bytes.

## Operation

- Edge detection:
  - Registers `rq_d` and `rd_d` hold the previous-cycle `SNDRQ` and `SCPU_RD`.
  - `push_ev = SNDRQ & ~rq_d`; `ack_ev = SCPU_RD & ~rd_d`; `pop_ev = ~SCPU_RD & rd_d`.
  - During `RESET`, `rq_d` and `rd_d` load the current input levels. A strobe held high across reset release therefore produces no event.
- FIFO:
  - Circular buffer with `wptr` and `rptr`, each DEPTH_LOG2 bits, wrapping modulo depth. `COUNT` is the occupancy.
  - A pop is performed iff `pop_ev` and COUNT != 0; on an empty FIFO, `pop_ev` is ignored.
  - A push is performed iff `push_ev` and (COUNT != depth or a pop is performed in the same cycle).
  - A push that is not performed sets `OVF`. The byte is dropped and the FIFO contents are unchanged.
  - Simultaneous push and pop: both take effect and COUNT is unchanged. This includes the full case.
  - Pointer wrap-around needs no special handling.
- `SCPU_DO`: on each edge, loads `mem[rptr]` as updated by this cycle's pop/push if the post-update COUNT != 0; otherwise it holds.
- NMI state machine (`SNDNMI = (state == ASSERT)`):
  - IDLE: if COUNT != 0, go to ASSERT.
  - ASSERT: on `ack_ev`, go to WAITPOP.
  - WAITPOP: on `pop_ev`, go to GAP and load the gap counter with NMI_GAP-1.
  - GAP: decrement the counter; at 0, go to IDLE.
  - A `pop_ev` seen in ASSERT (the read edge was missed) goes directly to GAP.
  - `ack_ev` and `pop_ev` in IDLE or GAP are ignored by the state machine; the FIFO still pops.
- Reset values: FIFO empty, COUNT=0, `SCPU_DO`=0x00, `SNDNMI`=0, `FULL`=0, `OVF`=0, state IDLE, both pointers 0. A reset mid-sequence discards all queued bytes.

## Timing

- Push:
  - `SNDRQ` first seen high at edge k: COUNT and `FULL` update at edge k.
  - `SCPU_DO` shows the byte at edge k if the FIFO was empty before.
  - `SNDNMI` rises at edge k+1 (IDLE→ASSERT).
- Ack: `SCPU_RD` first seen high at edge m, so `SNDNMI` is low after edge m.
- Pop:
  - `SCPU_RD` first seen low at edge p: COUNT decrements at edge p and `SCPU_DO` advances at edge p.
  - If COUNT != 0 after the pop, `SNDNMI` re-asserts at edge p+NMI_GAP+1. The guaranteed low time is at least NMI_GAP+1 cycles, which makes a fresh edge for the Z80.
- One main-CPU write of 16 `CLK48M` cycles with `SNDRQ` high produces exactly one push.
- Back-to-back rising edges of `SNDRQ` two cycles apart are both accepted.

## Test plan

- Single command: after reset, pulse `SNDRQ` for 16 cycles with `SNDNO`=0x5A.
  - Required: COUNT=1, `SCPU_DO`=0x5A, `SNDNMI` high one cycle after the edge.
  - Then raise `SCPU_RD` for 8 cycles: `SNDNMI` low on the rising edge, COUNT=0 on the falling edge, `SNDNMI` stays low.
- Queue of 3: push 0x01, 0x02, 0x03, then perform three read cycles.
  - Required: `SCPU_DO` sequence 0x01→0x02→0x03, with `SNDNMI` re-asserting exactly NMI_GAP+1 cycles after pops 1 and 2.
  - Required: no re-assert after pop 3.
- Overflow: push 0x10..0x14 (5 bytes, depth 4) with no reads.
  - Required: `FULL`=1 after the 4th push, `OVF`=1 after the 5th, COUNT=4.
  - Draining yields 0x10..0x13; `OVF` stays 1 until `RESET`.
- Simultaneous events: with the FIFO full, make a `pop_ev` and a `push_ev` (0xEE) occur in the same cycle.
  - Required: COUNT stays 4, `OVF` stays 0, and 0xEE is the last byte drained.
  - Repeat on an empty FIFO: the push succeeds, the pop is ignored, and COUNT=1.
- Reset mid-operation: with 2 bytes queued, `SNDNMI` high, and `SNDRQ` held high, assert `RESET` for 2 cycles and release while `SNDRQ` is still high.
  - Required: all outputs at reset values and no spurious push after release.
- Wrap-around: run 10 push/read cycles of 0x80+i.
  - Required: pointers wrap, every byte is read out in order, `OVF`=0.
